// File: rtl/ldtu_ctrl_pkg.sv
// Shared constants and types for the gain-selection configuration sequencer.
package ldtu_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned SAT_W   = 12;
  localparam int unsigned SHIFT_W = 2;

  // Sequencer states
  localparam logic [STATE_W-1:0] ST_IDLE       = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_QUIET = 2'd1;
  localparam logic [STATE_W-1:0] ST_APPLY      = 2'd2;
  localparam logic [STATE_W-1:0] ST_SETTLE     = 2'd3;

  // GAIN_SEL_MODE codes
  localparam logic [MODE_W-1:0] MODE_W8  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_W16 = 2'b01;
  localparam logic [MODE_W-1:0] MODE_G10 = 2'b10;
  localparam logic [MODE_W-1:0] MODE_G1  = 2'b11;

  localparam logic [SAT_W-1:0] SAT_DEFAULT = 12'hfff;

  // One complete set of datapath settings, applied atomically
  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [SAT_W-1:0]   sat;
    logic [SHIFT_W-1:0] shift;
  } gain_cfg_t;

  localparam gain_cfg_t CFG_RESET = '{mode: MODE_W8, sat: SAT_DEFAULT, shift: 2'b00};

endpackage

// File: rtl/ldtu_quiet_det.sv
// Quiet-baseline qualifier: counts consecutive quiet samples while enabled.
module ldtu_quiet_det #(
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data_msb,
  input  logic baseline_flag,
  output logic done_c
);

  localparam int unsigned QCNT_W = $clog2(QUIET_CYCLES + 1);

  logic              quiet_c;
  logic [QCNT_W-1:0] qcnt_q;
  logic [QCNT_W-1:0] qcnt_d;

  assign quiet_c = baseline_flag & ~data_msb;

  // Run length of quiet samples; held at zero whenever not enabled
  always_comb begin
    qcnt_d = '0;
    if (en && quiet_c) begin
      qcnt_d = (qcnt_q == '1) ? qcnt_q : qcnt_q + QCNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt_q <= '0;
    end else begin
      qcnt_q <= qcnt_d;
    end
  end

  // This sample completes the required quiet run
  assign done_c = en & quiet_c & (qcnt_q == QCNT_W'(QUIET_CYCLES - 1));

endmodule

// File: rtl/ldtu_gainsel_ctrl.sv
// Configuration sequencer: applies gain-selection settings on a quiet baseline
// and masks encoder data while the look-ahead window refills.
module ldtu_gainsel_ctrl #(
  parameter int unsigned QUIET_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SETTLE_W8      = 12,
  parameter int unsigned SETTLE_W16     = 20,
  parameter int unsigned CNT_W          = 11
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  input  logic [11:0] req_sat,
  input  logic [1:0]  req_shift,
  input  logic        data_msb,
  input  logic        baseline_flag,
  output logic [1:0]  GAIN_SEL_MODE,
  output logic [11:0] SATURATION_value,
  output logic [1:0]  shift_gain_10,
  output logic        data_valid,
  output logic        busy,
  output logic        req_ack,
  output logic        timeout_err
);

  import ldtu_ctrl_pkg::*;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;       // timeout count in WAIT_QUIET, settle count in SETTLE
  logic               pend_q, pend_d;
  gain_cfg_t          shadow_q, shadow_d;
  gain_cfg_t          cfg_q, cfg_d;
  logic               data_valid_q, data_valid_d;
  logic               busy_q, busy_d;
  logic               req_ack_q, req_ack_d;
  logic               timeout_err_q, timeout_err_d;
  logic               waiting_c;
  logic               quiet_done_c;

  assign waiting_c = (state_q == ST_WAIT_QUIET);

  ldtu_quiet_det #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet_det (
    .clk           (CLK),
    .rst           (rst),
    .en            (waiting_c),
    .data_msb      (data_msb),
    .baseline_flag (baseline_flag),
    .done_c        (quiet_done_c)
  );

  // Next-state, shadow capture and output computation
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    pend_d        = pend_q;
    shadow_d      = shadow_q;
    cfg_d         = cfg_q;
    req_ack_d     = 1'b0;
    timeout_err_d = timeout_err_q;

    // Last request wins; requests arriving during APPLY are not taken
    if (req_valid && (state_q != ST_APPLY)) begin
      shadow_d = '{mode: req_mode, sat: req_sat, shift: req_shift};
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT_QUIET;
          cyc_d   = '0;
        end
      end
      ST_WAIT_QUIET: begin
        if (quiet_done_c) begin
          state_d = ST_APPLY;
        end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_APPLY;
          timeout_err_d = 1'b1;
        end else begin
          cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        cfg_d     = shadow_q;
        req_ack_d = 1'b1;
        state_d   = ST_SETTLE;
        // Window length depends on the mode being applied; no refill if nothing changes
        if (shadow_q == cfg_q) begin
          cyc_d = '0;
        end else begin
          case (shadow_q.mode)
            MODE_W16:                   cyc_d = CNT_W'(SETTLE_W16);
            MODE_W8, MODE_G10, MODE_G1: cyc_d = CNT_W'(SETTLE_W8);
            default:                    cyc_d = CNT_W'(SETTLE_W8);
          endcase
        end
      end
      ST_SETTLE: begin
        if (req_valid) begin
          pend_d = 1'b1;
        end
        if (cyc_q == '0) begin
          if (pend_q || req_valid) begin
            state_d = ST_WAIT_QUIET;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cyc_d   = CNT_W'(SETTLE_W8);
      end
    endcase

    data_valid_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset leaves the window masked
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= ST_SETTLE;
      cyc_q         <= CNT_W'(SETTLE_W8);
      pend_q        <= 1'b0;
      shadow_q      <= CFG_RESET;
      cfg_q         <= CFG_RESET;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      req_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      pend_q        <= pend_d;
      shadow_q      <= shadow_d;
      cfg_q         <= cfg_d;
      data_valid_q  <= data_valid_d;
      busy_q        <= busy_d;
      req_ack_q     <= req_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign GAIN_SEL_MODE    = cfg_q.mode;
  assign SATURATION_value = cfg_q.sat;
  assign shift_gain_10    = cfg_q.shift;
  assign data_valid       = data_valid_q;
  assign busy             = busy_q;
  assign req_ack          = req_ack_q;
  assign timeout_err      = timeout_err_q;

endmodule
